// File: rtl/eco32f_pkg.sv
// Shared encodings for the eco32f multiply/divide unit: divider FSM states and
// bit positions of the operation-select vector built from the ex_op_* strobes.
package eco32f_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    localparam int OP_MUL  = 0;
    localparam int OP_DIV  = 1;
    localparam int OP_DIVU = 2;
    localparam int OP_REM  = 3;
    localparam int OP_REMU = 4;
    localparam int OP_W    = 5;

endpackage

// File: rtl/eco32f_mul_pipe.sv
// Fixed-latency low-half multiplier: the product is formed at issue and carried
// down a register chain alongside a valid bit; flush kills everything in flight.
module eco32f_mul_pipe #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] prod_in;
    assign prod_in = x * y;

    // The output register in the parent supplies the last stage of latency.
    generate
        if (MUL_STAGES == 1) begin : g_comb
            assign out_valid = in_valid;
            assign product   = prod_in;
        end else begin : g_pipe
            logic [MUL_STAGES-2:0] vld_q;
            logic [WIDTH-1:0]      prod_q [MUL_STAGES-1];

            // NOTE: non-blocking so each stage captures its neighbour's pre-edge value.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= in_valid;
                    for (int i = 1; i < MUL_STAGES - 1; i++) vld_q[i] <= vld_q[i-1];
                end
            end

            // NOTE: product data is not reset; the valid bits alone say whether it means anything.
            always_ff @(posedge clk) begin
                prod_q[0] <= prod_in;
                for (int i = 1; i < MUL_STAGES - 1; i++) prod_q[i] <= prod_q[i-1];
            end

            assign out_valid = vld_q[MUL_STAGES-2];
            assign product   = prod_q[MUL_STAGES-2];
        end
    endgenerate

endmodule

// File: rtl/eco32f_muldiv.sv
// EX-stage multiply/divide unit: pipelined multiply plus a radix-2 restoring
// divider (signed/unsigned quotient and remainder) sharing one result bus.
module eco32f_muldiv #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic             ex_op_mul,
    input  logic             ex_op_div,
    input  logic             ex_op_divu,
    input  logic             ex_op_rem,
    input  logic             ex_op_remu,
    input  logic [WIDTH-1:0] ex_x,
    input  logic [WIDTH-1:0] ex_y,
    output logic             busy,
    output logic             res_valid,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);

    import eco32f_pkg::*;

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_e       state_q, state_d;
    logic [OP_W-1:0]  op_sel;
    logic             accept, mul_issue, div_issue;
    logic             signed_op, rem_op, x_neg, y_neg;
    logic [WIDTH-1:0] x_mag, y_mag;

    logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q_neg_q, r_neg_q, rem_op_q, zero_q;
    logic [WIDTH:0]   trial, diff;
    logic             fits;
    logic [WIDTH-1:0] quo_fix, rem_fix, div_result;

    logic             mul_valid;
    logic [WIDTH-1:0] mul_product;

    assign op_sel[OP_MUL]  = ex_op_mul;
    assign op_sel[OP_DIV]  = ex_op_div;
    assign op_sel[OP_DIVU] = ex_op_divu;
    assign op_sel[OP_REM]  = ex_op_rem;
    assign op_sel[OP_REMU] = ex_op_remu;

    assign busy      = (state_q == ST_DIV) || (state_q == ST_FIX);
    assign accept    = ex_valid && !busy && !flush;
    assign mul_issue = accept && op_sel[OP_MUL];
    assign div_issue = accept && (op_sel[OP_DIV] || op_sel[OP_DIVU] ||
                                  op_sel[OP_REM] || op_sel[OP_REMU]);

    // Divide magnitudes; MIN's magnitude 2^(WIDTH-1) is still exact as unsigned.
    assign signed_op = op_sel[OP_DIV] || op_sel[OP_REM];
    assign rem_op    = op_sel[OP_REM] || op_sel[OP_REMU];
    assign x_neg     = signed_op && ex_x[WIDTH-1];
    assign y_neg     = signed_op && ex_y[WIDTH-1];
    assign x_mag     = x_neg ? -ex_x : ex_x;
    assign y_mag     = y_neg ? -ex_y : ex_y;

    eco32f_mul_pipe #(
        .WIDTH      (WIDTH),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (mul_issue),
        .x         (ex_x),
        .y         (ex_y),
        .out_valid (mul_valid),
        .product   (mul_product)
    );

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign trial = {rem_q, quo_q[WIDTH-1]};
    assign diff  = trial - {1'b0, dvs_q};
    assign fits  = !diff[WIDTH];

    always_ff @(posedge clk) begin
        if (div_issue) begin
            quo_q    <= x_mag;
            rem_q    <= '0;
            dvs_q    <= y_mag;
            cnt_q    <= CNT_W'(WIDTH - 1);
            q_neg_q  <= x_neg ^ y_neg;
            r_neg_q  <= x_neg;
            rem_op_q <= rem_op;
            zero_q   <= (ex_y == '0);
        end else if (state_q == ST_DIV) begin
            quo_q <= {quo_q[WIDTH-2:0], fits};
            rem_q <= fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign quo_fix    = q_neg_q ? -quo_q : quo_q;
    assign rem_fix    = r_neg_q ? -rem_q : rem_q;
    assign div_result = zero_q ? '0 : (rem_op_q ? rem_fix : quo_fix);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: state_d = div_issue ? ST_DIV : ST_IDLE;
            ST_DIV:           if (cnt_q == '0) state_d = ST_FIX;
            ST_FIX:           state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // Result register holds the last value between pulses; flush suppresses the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            result    <= '0;
            div_zero  <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (!flush) begin
                if (state_q == ST_FIX) begin
                    res_valid <= 1'b1;
                    result    <= div_result;
                    div_zero  <= zero_q;
                end else if (mul_valid) begin
                    res_valid <= 1'b1;
                    result    <= mul_product;
                    div_zero  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_eco32f_muldiv.sv
// Directed self-checking bench for eco32f_muldiv (WIDTH=32, MUL_STAGES=2).
module tb_eco32f_muldiv;

    localparam logic [4:0] OP_MUL  = 5'b00001;
    localparam logic [4:0] OP_DIV  = 5'b00010;
    localparam logic [4:0] OP_DIVU = 5'b00100;
    localparam logic [4:0] OP_REM  = 5'b01000;
    localparam logic [4:0] OP_REMU = 5'b10000;

    logic        clk = 1'b0;
    logic        rst, flush, ex_valid;
    logic        ex_op_mul, ex_op_div, ex_op_divu, ex_op_rem, ex_op_remu;
    logic [31:0] ex_x, ex_y;
    logic        busy, res_valid, div_zero;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    eco32f_muldiv #(.WIDTH(32), .MUL_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_op_mul  (ex_op_mul),
        .ex_op_div  (ex_op_div),
        .ex_op_divu (ex_op_divu),
        .ex_op_rem  (ex_op_rem),
        .ex_op_remu (ex_op_remu),
        .ex_x       (ex_x),
        .ex_y       (ex_y),
        .busy       (busy),
        .res_valid  (res_valid),
        .result     (result),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [4:0] ops);
        {ex_op_remu, ex_op_rem, ex_op_divu, ex_op_div, ex_op_mul} = ops;
    endtask

    // Present one op during the current cycle t; returns in cycle t+1.
    task automatic issue(input logic [4:0] ops, input logic [31:0] x, input logic [31:0] y);
        ex_valid = 1'b1;
        set_ops(ops);
        ex_x = x;
        ex_y = y;
        step();
        ex_valid = 1'b0;
        set_ops(5'b0);
    endtask

    // Called at cycle t+start; waits (bounded) for the pulse and checks its cycle and payload.
    task automatic wait_pulse(input int start, input int lat, input string tag,
                              input logic [31:0] exp_r, input logic exp_dz);
        int cyc = start;
        while (res_valid !== 1'b1 && cyc < lat + 4) begin
            step();
            cyc++;
        end
        check({tag, "_lat"}, cyc, lat);
        check({tag, "_res"}, result, exp_r);
        check({tag, "_dz"}, {31'b0, div_zero}, {31'b0, exp_dz});
    endtask

    // Full divide: busy for t+1..t+33, single pulse at t+34 with busy low.
    task automatic div_run(input string tag, input logic [4:0] ops, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] exp_r, input logic exp_dz);
        int bad = 0;
        issue(ops, x, y);
        for (int k = 1; k <= 33; k++) begin
            if (busy !== 1'b1 || res_valid !== 1'b0) bad++;
            step();
        end
        check({tag, "_busy_window"}, bad, 0);
        check({tag, "_valid"}, {31'b0, res_valid}, 32'd1);
        check({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
        check({tag, "_res"}, result, exp_r);
        check({tag, "_dz"}, {31'b0, div_zero}, {31'b0, exp_dz});
        step();
        check({tag, "_one_pulse"}, {31'b0, res_valid}, 32'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_x = '0; ex_y = '0;
        set_ops(5'b0);
        repeat (3) step();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_valid", {31'b0, res_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_dz", {31'b0, div_zero}, 32'd0);
        rst = 1'b0;
        step();

        // Single multiply, latency 2.
        issue(OP_MUL, 32'd7, 32'd6);
        check("mul7x6_t1_quiet", {31'b0, res_valid}, 32'd0);
        wait_pulse(1, 2, "mul7x6", 32'd42, 1'b0);
        step();
        check("mul7x6_one_pulse", {31'b0, res_valid}, 32'd0);
        check("mul7x6_hold", result, 32'd42);

        // Three back-to-back multiplies: pulses at t+2, t+3, t+4.
        issue(OP_MUL, 32'hFFFF_FFFF, 32'd2);
        check("mul3_t1_quiet", {31'b0, res_valid}, 32'd0);
        issue(OP_MUL, 32'd3, 32'd5);
        check("mul3_a_valid", {31'b0, res_valid}, 32'd1);
        check("mul3_a_res", result, 32'hFFFF_FFFE);
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000);
        check("mul3_b_valid", {31'b0, res_valid}, 32'd1);
        check("mul3_b_res", result, 32'd15);
        step();
        check("mul3_c_valid", {31'b0, res_valid}, 32'd1);
        check("mul3_c_res", result, 32'd0);
        step();
        check("mul3_drained", {31'b0, res_valid}, 32'd0);

        // Divides and remainders, signed and unsigned.
        div_run("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0);
        div_run("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0);
        div_run("divu_big",   OP_DIVU, 32'hFFFF_FFF9, 32'd2,        32'h7FFF_FFFC, 1'b0);
        div_run("div_100_m7", OP_DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
        div_run("rem_100_m7", OP_REM,  32'd100,       32'hFFFF_FFF9, 32'd2,        1'b0);
        div_run("div_min_m1", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        div_run("rem_min_m1", OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1'b0);
        div_run("remu_5_0",   OP_REMU, 32'd5,         32'd0,        32'd0,        1'b1);
        div_run("div_m7_0",   OP_DIV,  32'hFFFF_FFF9, 32'd0,        32'd0,        1'b1);

        // MUL at t, DIV at t+1: mul pulse t+2, div pulse t+35.
        issue(OP_MUL, 32'd3, 32'd4);
        issue(OP_DIVU, 32'd50, 32'd7);
        check("muldiv_mul_valid", {31'b0, res_valid}, 32'd1);
        check("muldiv_mul_res", result, 32'd12);
        check("muldiv_mul_dz", {31'b0, div_zero}, 32'd0);
        step();
        wait_pulse(2, 34, "muldiv_div", 32'd7, 1'b0);

        // MUL offered while busy must be dropped; the divide pulse is the only one.
        issue(OP_DIVU, 32'd20, 32'd3);
        issue(OP_MUL, 32'd9, 32'd9);
        wait_pulse(2, 34, "mul_blocked", 32'd6, 1'b0);
        step();
        step();
        check("mul_blocked_no_late", {31'b0, res_valid}, 32'd0);

        // Flush mid-divide at t+10.
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (9) step();
        check("flush_busy_before", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy_after", {31'b0, busy}, 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (res_valid !== 1'b0) seen++;
            step();
        end
        check("flush_no_pulse", seen, 0);
        check("flush_result_hold", result, 32'd6);

        // Flush kills an in-flight multiply.
        issue(OP_MUL, 32'd4, 32'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_mul_no_pulse", {31'b0, res_valid}, 32'd0);
        step();
        check("flush_mul_no_late", {31'b0, res_valid}, 32'd0);

        // ex_valid together with flush is not accepted.
        flush = 1'b1;
        issue(OP_DIV, 32'd10, 32'd2);
        flush = 1'b0;
        check("flush_issue_busy", {31'b0, busy}, 32'd0);
        step();
        step();
        check("flush_issue_no_pulse", {31'b0, res_valid}, 32'd0);

        // Reset mid-divide clears all outputs.
        issue(OP_MUL, 32'd5, 32'd5);
        step();
        check("pre_rst_res", result, 32'd25);
        issue(OP_DIV, 32'd77, 32'd5);
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_valid", {31'b0, res_valid}, 32'd0);
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_dz", {31'b0, div_zero}, 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (res_valid !== 1'b0) seen++;
            step();
        end
        check("rst_mid_no_pulse", seen, 0);

        // Recovery after reset.
        issue(OP_MUL, 32'd2, 32'd3);
        wait_pulse(1, 2, "post_rst_mul", 32'd6, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
